// File: rtl/dsi_seq_pkg.sv
// Shared codes, FSM encoding and LP level-pattern breakpoints for the DSI lane sequencer.
package dsi_seq_pkg;

  // Per-lane state codes
  localparam logic [1:0] ST_DRIVE = 2'b00;
  localparam logic [1:0] ST_HOLD  = 2'b01;
  localparam logic [1:0] ST_LP    = 2'b10;
  localparam logic [1:0] ST_LP00  = 2'b11;

  // Per-lane level codes
  localparam logic [1:0] LV_L01 = 2'b01;
  localparam logic [1:0] LV_L10 = 2'b10;
  localparam logic [1:0] LV_L11 = 2'b11;

  // Clock-lane DAC codes
  localparam logic [7:0] DAC_LP_P = 8'hBF;
  localparam logic [7:0] DAC_LP_N = 8'hFF;
  localparam logic [7:0] DAC_HS   = 8'h16;

  // LP pattern breakpoints (first cycle index of the next level)
  localparam int unsigned BRK_N_L01 = 57;
  localparam int unsigned BRK_P_L01 = 60;
  localparam int unsigned BRK_P_L10 = 110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STARTUP,
    S_LP00,
    S_DATA,
    S_TRAIL,
    S_HIGH,
    S_POST
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dsi_lp_pattern.sv
// Maps bus type and cycle index within an LP period to the lane level code.
module dsi_lp_pattern
  import dsi_seq_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          bus_p,
  input  logic [CW-1:0] cyc,
  output logic [1:0]    level
);

  // P: L01 / L10 / L11 segments; N: L01 then L11
  always_comb begin
    level = LV_L11;
    if (bus_p) begin
      if (cyc < CW'(BRK_P_L01))      level = LV_L01;
      else if (cyc < CW'(BRK_P_L10)) level = LV_L10;
    end else begin
      if (cyc < CW'(BRK_N_L01))      level = LV_L01;
    end
  end

endmodule

// File: rtl/dsi_lane_sequencer.sv
// Multi-lane MIPI-DSI test-pattern sequencer: startup, LP00 entry, data burst,
// trail, long-high and post periods, repeating while enabled.
module dsi_lane_sequencer
  import dsi_seq_pkg::*;
#(
  parameter int unsigned LANES          = 1,
  parameter int unsigned STARTUP_CYC    = 1080000,
  parameter int unsigned T_LP00         = 599,
  parameter int unsigned SYMS_PER_BURST = 1334,
  parameter int unsigned T_SYM          = 903,
  parameter int unsigned T_SYM_DRIVE    = 851,
  parameter int unsigned T_TRAIL        = 888,
  parameter int unsigned TRAIL_COUNT    = 533,
  parameter int unsigned T_HIGH         = 4712,
  parameter int unsigned POST_COUNT     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               bus_type,
  input  logic               sym_valid,
  input  logic [2*LANES-1:0] sym_level,
  output logic               sym_ready,
  output logic [2*LANES-1:0] lane_state,
  output logic [2*LANES-1:0] lane_level,
  output logic               mipi_clk,
  output logic [7:0]         mipi_clk_dac,
  output logic               frame_start,
  output logic               frame_done,
  output logic               underrun,
  output logic               busy
);

  localparam int unsigned MAXP = max_u(max_u(max_u(STARTUP_CYC, T_LP00), max_u(SYMS_PER_BURST, T_SYM)),
                                       max_u(max_u(T_TRAIL, TRAIL_COUNT), max_u(T_HIGH, POST_COUNT)));
  localparam int unsigned CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYC - 1);
  localparam logic [CW-1:0] LP00_LAST    = CW'(T_LP00 - 1);
  localparam logic [CW-1:0] SYM_LAST     = CW'(T_SYM - 1);
  localparam logic [CW-1:0] DRIVE_END    = CW'(T_SYM_DRIVE);
  localparam logic [CW-1:0] SYMS_LAST    = CW'(SYMS_PER_BURST - 1);
  localparam logic [CW-1:0] TRAIL_LAST   = CW'(T_TRAIL - 1);
  localparam logic [CW-1:0] TRAILS_LAST  = CW'(TRAIL_COUNT - 1);
  localparam logic [CW-1:0] HIGH_LAST    = CW'(T_HIGH - 1);
  localparam logic [CW-1:0] POSTS_LAST   = CW'(POST_COUNT - 1);

  seq_state_e         state, state_d;
  logic [CW-1:0]      cyc, cyc_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               bus_lat, bus_lat_d;
  logic [2*LANES-1:0] sym_q, sym_d;
  logic               und_d;

  logic [2*LANES-1:0] lane_state_d, lane_level_d;
  logic               mipi_clk_d, sym_ready_d, frame_start_d, frame_done_d, busy_d;
  logic [7:0]         dac_d;

  logic               pat_bus_p;
  logic [1:0]         pat_level;

  // Next state, phase counters, bus-type latch and symbol capture
  always_comb begin
    state_d   = state;
    cyc_d     = cyc + 1'b1;
    cnt_d     = cnt;
    bus_lat_d = bus_lat;
    sym_d     = sym_q;
    und_d     = underrun;

    case (state)
      S_IDLE: begin
        cyc_d = '0;
        cnt_d = '0;
        if (enable) state_d = S_STARTUP;
      end
      S_STARTUP: begin
        if (cyc == STARTUP_LAST) begin
          state_d = S_LP00;
          cyc_d   = '0;
        end
      end
      S_LP00: begin
        if (cyc == LP00_LAST) begin
          state_d = S_DATA;
          cyc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (cyc == SYM_LAST) begin
          cyc_d = '0;
          if (cnt == SYMS_LAST) begin
            state_d = S_TRAIL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (cyc == TRAIL_LAST) begin
          cyc_d = '0;
          if (cnt == TRAILS_LAST) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (cyc == HIGH_LAST) begin
          state_d = S_POST;
          cyc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_POST: begin
        if (cyc == TRAIL_LAST) begin
          cyc_d = '0;
          if (cnt == POSTS_LAST) begin
            cnt_d   = '0;
            state_d = enable ? S_LP00 : S_IDLE;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (state_d == S_LP00 && state != S_LP00) bus_lat_d = bus_type;

    // sym_ready is registered, so it marks exactly the capture edge
    if (sym_ready) begin
      if (sym_valid) begin
        sym_d = sym_level;
      end else begin
        und_d = 1'b1;
        if (state == S_LP00) sym_d = {LANES{LV_L01}};
      end
    end
  end

  assign pat_bus_p = (state_d == S_HIGH) ? 1'b1 : bus_lat_d;

  dsi_lp_pattern #(.CW(CW)) u_pattern (
    .bus_p (pat_bus_p),
    .cyc   (cyc_d),
    .level (pat_level)
  );

  // Output decode from the next-state values so registered outputs line up with the state they describe
  always_comb begin
    lane_state_d  = {LANES{ST_LP}};
    lane_level_d  = {LANES{LV_L11}};
    mipi_clk_d    = 1'b1;
    dac_d         = DAC_LP_N;
    sym_ready_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    busy_d        = (state_d != S_IDLE);

    case (state_d)
      S_STARTUP: begin
        dac_d = bus_type ? DAC_LP_P : DAC_LP_N;
      end
      S_LP00: begin
        lane_state_d  = {LANES{ST_LP00}};
        mipi_clk_d    = 1'b0;
        dac_d         = DAC_HS;
        frame_start_d = (cyc_d == '0);
        sym_ready_d   = (cyc_d == LP00_LAST);
      end
      S_DATA: begin
        lane_state_d = (cyc_d < DRIVE_END) ? {LANES{ST_DRIVE}} : {LANES{ST_HOLD}};
        lane_level_d = sym_d;
        mipi_clk_d   = 1'b0;
        dac_d        = DAC_HS;
        sym_ready_d  = (cyc_d == SYM_LAST) && (cnt_d != SYMS_LAST);
      end
      S_TRAIL, S_HIGH, S_POST: begin
        lane_level_d = {LANES{pat_level}};
        dac_d        = bus_lat_d ? DAC_LP_P : DAC_LP_N;
        frame_done_d = (state_d == S_POST) && (cyc_d == TRAIL_LAST) && (cnt_d == POSTS_LAST);
      end
      default: ;
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cyc      <= '0;
      cnt      <= '0;
      bus_lat  <= 1'b0;
      sym_q    <= {LANES{LV_L01}};
      underrun <= 1'b0;
    end else begin
      state    <= state_d;
      cyc      <= cyc_d;
      cnt      <= cnt_d;
      bus_lat  <= bus_lat_d;
      sym_q    <= sym_d;
      underrun <= und_d;
    end
  end

  // Registered lane and clock-lane outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_state   <= {LANES{ST_LP}};
      lane_level   <= {LANES{LV_L11}};
      mipi_clk     <= 1'b1;
      mipi_clk_dac <= DAC_LP_N;
      sym_ready    <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      lane_state   <= lane_state_d;
      lane_level   <= lane_level_d;
      mipi_clk     <= mipi_clk_d;
      mipi_clk_dac <= dac_d;
      sym_ready    <= sym_ready_d;
      frame_start  <= frame_start_d;
      frame_done   <= frame_done_d;
      busy         <= busy_d;
    end
  end

endmodule
